// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the op-class decode helpers.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // Ops that iterate through CALC/FIX; MTHI/MTLO/NOP/undefined never do.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor keeps shifted < 2*divisor, so diff's MSB is a clean borrow.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/md_hilo_iter.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done
// handshake. Define MDU_EARLY_OUT_EN to let multiplies exit CALC early.
module md_hilo_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state_q, state_nxt;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_step, mul_nxt, div_nxt;
  logic [WIDTH-1:0]   opb_q, a_raw_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_mul_q, sign_a_q, sign_b_q;
  logic               early;

  logic               start_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign start_sgn = op_is_signed(op);
  assign a_mag     = (start_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (start_sgn && b[WIDTH-1]) ? -b : b;

  // Shift-add step: conditional add into the upper half, then shift right.
  logic [WIDTH:0] add_hi;
  assign add_hi  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt = {add_hi, acc_q[WIDTH-1:1]};

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
    .dvd_bit (acc_q[WIDTH-1]),
    .divisor (opb_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign div_nxt = {rem_nxt, acc_q[WIDTH-2:0], q_bit};

`ifdef MDU_EARLY_OUT_EN
  // After this step the unconsumed multiplier bits sit in mul_nxt[cnt-2:0].
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask = ~({WIDTH{1'b1}} << (cnt_q - 1'b1));
  assign early    = is_mul_q && ((mul_nxt[WIDTH-1:0] & rem_mask) == '0);

  always_comb begin
    acc_step = is_mul_q ? mul_nxt : div_nxt;
    if (early) acc_step = mul_nxt >> (cnt_q - 1'b1);
  end
`else
  assign early = 1'b0;

  always_comb begin
    acc_step = is_mul_q ? mul_nxt : div_nxt;
  end
`endif

  // Sign correction and special cases applied on the FIX->IDLE edge.
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               dz_hit;

  assign dz_hit = !is_mul_q && (opb_q == '0);

  always_comb begin
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_mul_q)
      result = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    else if (dz_hit)
      result = {a_raw_q, {WIDTH{1'b1}}};
    else
      result = {rem_fix, quot_fix};
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start && op_is_arith(op)) state_nxt = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(1) || early) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opb_q       <= '0;
      a_raw_q     <= '0;
      cnt_q       <= '0;
      is_mul_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && op_is_arith(op)) begin
            is_mul_q    <= op_is_mul(op);
            sign_a_q    <= start_sgn && a[WIDTH-1];
            sign_b_q    <= start_sgn && b[WIDTH-1];
            a_raw_q     <= a;
            cnt_q       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            // Multiply: multiplicand = |a|, multiplier = |b| in the low half.
            opb_q       <= op_is_mul(op) ? a_mag : b_mag;
            acc_q       <= {{WIDTH{1'b0}}, (op_is_mul(op) ? b_mag : a_mag)};
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt_q <= early ? '0 : cnt_q - 1'b1;
        end
        S_FIX: begin
          hi   <= result[2*WIDTH-1:WIDTH];
          lo   <= result[WIDTH-1:0];
          done <= 1'b1;
          if (dz_hit) div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/md_hilo_iter.md
Name: md_hilo_iter

Overview:
Parametrised iterative multiply/divide unit with HI/LO registers. It is the multi-cycle successor to the single-cycle mul/div block in the CPU datapath. It accepts one operation per start pulse, holds busy while iterating (the CPU stalls on busy), and writes HI/LO atomically at completion. It adds a start/busy/done handshake, a divide-by-zero flag and defined overflow results.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and at least 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  3  operation code (see package): NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  in  WIDTH  rs operand / dividend / MTHI, MTLO data
b  in  WIDTH  rt operand / divisor
busy  out  1  high while an operation is iterating
done  out  1  one-cycle pulse: HI/LO updated on the previous edge
div_by_zero  out  1  sticky until next start; set when DIV/DIVU has b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0. Reset mid-operation abandons the op with no HI/LO write.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - MULT/MULTU/DIV/DIVU: latch magnitudes and signs, clear div_by_zero, counter=WIDTH, go to CALC.
  - MTHI/MTLO: write hi/lo from a on the same edge, stay IDLE, no done and no busy.
  - NOP or undefined op: ignored.
- CALC: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle on unsigned magnitudes. Decrement counter; go to FIX when counter reaches 1.
- FIX: apply sign correction. Signed multiply negates the 2*WIDTH product if sign_a^sign_b. Signed divide: quotient sign = sign_a^sign_b; remainder sign = sign_a. Write {hi,lo} on the FIX->IDLE edge; done=1 for the following cycle.
- busy = (state!=IDLE). Latency from the start edge to HI/LO valid is WIDTH+1 edges; done is high in cycle WIDTH+2. A new start is accepted in the same cycle done is high.
- start while busy: ignored, including MTHI/MTLO. The CPU must stall.
- Operands are latched at start. Changes to a/b during busy have no effect.
- Divide by zero: lo = all ones, hi = a (raw dividend), div_by_zero=1. Full normal latency.
- Signed overflow (DIV, a=MIN_INT, b=-1): lo=MIN_INT, hi=0, div_by_zero=0.
- Multiply results are exact 2*WIDTH products: hi=upper half, lo=lower half.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: MULT/MULTU leave CALC as soon as the remaining multiplier bits are all zero (shift the accumulator by the remaining count in one step). Minimum multiply latency is 2 edges (b==0 or b==1); done timing shifts accordingly. Division is unaffected.
- Undefined: fixed WIDTH+1 latency for all operations.

Decomposition:
- Package md_pkg: op encodings (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), state enum {IDLE, CALC, FIX}.
- Sub-module md_div_step: combinational single restoring-division step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly WIDTH+2 cycles after start; busy high for WIDTH+1 cycles.
- MULTU a=0xFFFFFFFE, b=3 -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1. The next start clears div_by_zero.
- Start MULT, then pulse start with MTHI a=0x1234 at cycle 5 -> ignored; final hi/lo are the product only. In IDLE, MTLO a=0x55 -> lo=0x55 next cycle, no done.
- Start DIVU, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. Start issued right after reset completes correctly.
